// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray/binary conversion helpers for the async FIFO
// write- and read-side controllers.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int CONV_W             = 32;

  typedef logic [DEFAULT_ADDR_WIDTH:0]   ptr_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  // Conversions work on a wide zero-extended value so any pointer width up to
  // CONV_W can share them; callers cast the result back to their own width.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Binary + Gray pointer register pair with increment enable; the Gray copy is
// registered so a downstream synchronizer sees at most one bit change per edge.
module gray_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int W = DEFAULT_ADDR_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-2:0] addr,
  output logic [W-1:0] gray,
  output logic [W-1:0] gray_next
);

  logic [W-1:0] bin;
  logic [W-1:0] bin_next;

  assign bin_next  = bin + W'(inc);
  assign gray_next = W'(bin2gray(CONV_W'(bin_next)));
  assign addr      = bin[W-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag controller for the async FIFO.
// Define FIFO_WLEVEL_EN to build the wlevel/walmost_full occupancy path; otherwise both read 0.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  walmost_full,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rptr_full_cmp;

  // Accept decision uses only the registered full flag, so a read-pointer
  // advance in the same cycle cannot rescue a write at full.
  assign wr_accept = wr_en & ~wfull;

  gray_ptr_cnt #(.W(PW)) u_wcnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (wr_accept),
    .addr      (waddr),
    .gray      (wptr),
    .gray_next (wgray_next)
  );

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rptr_full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wfull     <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wfull     <= (wgray_next == rptr_full_cmp);
      woverflow <= woverflow | (wr_en & wfull);
    end
  end

`ifdef FIFO_WLEVEL_EN
  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] THRESH = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] wlevel_next;
  logic                walmost_full_next;

  // Modulo subtraction absorbs pointer wrap; result stays within 0..DEPTH.
  assign wbin_next         = PW'(gray2bin(CONV_W'(wgray_next)));
  assign rbin              = PW'(gray2bin(CONV_W'(wq2_rptr)));
  assign wlevel_next       = wbin_next - rbin;
  assign walmost_full_next = (DEPTH - wlevel_next) <= THRESH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= wlevel_next;
      walmost_full <= walmost_full_next;
    end
  end
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule
